// File: rtl/rv32i_dec_pkg.sv
// rv32i_dec_pkg: opcodes, one-hot class/format bit indices and the decoded bundle type
package rv32i_dec_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam int OP_LUI    = 0;
  localparam int OP_AUIPC  = 1;
  localparam int OP_JAL    = 2;
  localparam int OP_JALR   = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_LOAD   = 5;
  localparam int OP_IMM    = 6;
  localparam int OP_STORE  = 7;
  localparam int OP_SHIFT  = 8;
  localparam int OP_REG    = 9;
  localparam int OP_FENCE  = 10;
  localparam int OP_SYSTEM = 11;
  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_J = 4;
  localparam int FMT_U = 5;
  // imm is kept at 32 bits; the top sign-extends it to XLEN
  typedef struct packed {
    logic [11:0] op;
    logic [5:0]  fmt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic        muldiv;
  } dec_t;
endpackage

// File: rtl/inst_dec_comb.sv
// inst_dec_comb: combinational RV32I class/format/immediate decode with illegal check
// DEC_RV32M_EN: when defined, OP with funct7=0000001 decodes as a legal M-extension op
module inst_dec_comb
  import rv32i_dec_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);
`ifdef DEC_RV32M_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [11:0] op;
  logic [5:0] fmt;
  logic [31:0] imm;
  logic shift, bad, md;
  always_comb begin
    opc = inst[6:0];
    f3 = inst[14:12];
    f7 = inst[31:25];
    shift = opc == OPC_OP_IMM && f3[1:0] == 2'b01;
    op = '0;
    op[OP_LUI] = opc == OPC_LUI;
    op[OP_AUIPC] = opc == OPC_AUIPC;
    op[OP_JAL] = opc == OPC_JAL;
    op[OP_JALR] = opc == OPC_JALR;
    op[OP_BRANCH] = opc == OPC_BRANCH;
    op[OP_LOAD] = opc == OPC_LOAD;
    op[OP_IMM] = opc == OPC_OP_IMM && !shift;
    op[OP_STORE] = opc == OPC_STORE;
    op[OP_SHIFT] = shift;
    op[OP_REG] = opc == OPC_OP;
    op[OP_FENCE] = opc == OPC_FENCE;
    op[OP_SYSTEM] = opc == OPC_SYSTEM;
    fmt = '0;
    fmt[FMT_R] = op[OP_REG];
    fmt[FMT_I] = op[OP_JALR] | op[OP_LOAD] | op[OP_IMM] | op[OP_SHIFT] | op[OP_FENCE] | op[OP_SYSTEM];
    fmt[FMT_S] = op[OP_STORE];
    fmt[FMT_B] = op[OP_BRANCH];
    fmt[FMT_J] = op[OP_JAL];
    fmt[FMT_U] = op[OP_LUI] | op[OP_AUIPC];
    md = M_EN && op[OP_REG] && f7 == 7'h01;
    bad = inst[1:0] != 2'b11 || op == '0
      || (op[OP_REG] && !(f7 == 7'h00 || md || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
      || (op[OP_SHIFT] && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)))
      || (op[OP_BRANCH] && f3[2:1] == 2'b01)
      || (op[OP_LOAD] && (f3 == 3'd3 || f3[2:1] == 2'b11))
      || (op[OP_STORE] && f3 >= 3'd3)
      || (op[OP_JALR] && f3 != 3'd0);
    imm = fmt[FMT_U] ? {inst[31:12], 12'h000}
        : fmt[FMT_J] ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0}
        : fmt[FMT_B] ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0}
        : fmt[FMT_S] ? {{20{inst[31]}}, inst[31:25], inst[11:7]}
        : op[OP_SHIFT] ? {27'h0, inst[24:20]}
        : fmt[FMT_I] ? {{20{inst[31]}}, inst[31:20]}
        : 32'h0;
    dec.op = bad ? '0 : op;
    dec.fmt = bad ? '0 : fmt;
    dec.imm = bad ? '0 : imm;
    dec.illegal = bad;
    dec.muldiv = md && !bad;
    dec.funct3 = f3;
    dec.funct7 = f7;
    dec.rd = inst[11:7];
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
  end
endmodule

// File: rtl/inst_dec_queue.sv
// inst_dec_queue: instruction FIFO with valid/ready handshake feeding a registered RV32I decode bundle
// DEC_RV32M_EN: enables M-extension decode inside inst_dec_comb
module inst_dec_queue
  import rv32i_dec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [11:0]              out_op,
  output logic [5:0]               out_fmt,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_illegal,
  output logic                     out_muldiv,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [31:0] mem_inst [DEPTH];
  logic [PC_W-1:0] mem_pc [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, load;
  dec_t head, bnd;
  inst_dec_comb u_dec (.inst(mem_inst[rd_ptr]), .dec(head));
  assign in_ready = count != FULL;
  assign push = in_valid && in_ready;
  assign load = count != '0 && (!out_valid || out_ready);
  always_ff @(posedge clk)
    if (push && !flush) begin
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr] <= in_pc;
    end
  // flush shares the reset path so a concurrent push or load is dropped
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_valid <= 1'b0;
      out_pc <= '0;
      bnd <= '0;
    end else begin
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
        out_pc <= mem_pc[rd_ptr];
        bnd <= head;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
  assign out_op = bnd.op;
  assign out_fmt = bnd.fmt;
  assign out_funct3 = bnd.funct3;
  assign out_funct7 = bnd.funct7;
  assign out_rd = bnd.rd;
  assign out_rs1 = bnd.rs1;
  assign out_rs2 = bnd.rs2;
  assign out_imm = XLEN'($signed(bnd.imm));
  assign out_illegal = bnd.illegal;
  assign out_muldiv = bnd.muldiv;
endmodule

// File: doc/inst_dec_queue.md
Name: inst_dec_queue

Overview:
- Registered RV32I decode stage sitting between the fetch unit and the register-read/execute stage.
- Buffers fetched instructions and their PCs in a parametrised FIFO, then decodes the FIFO head into a registered output bundle.
- Compared with the combinational decoder it replaces, it adds a valid/ready handshake, a flush, illegal-instruction detection, and immediates sign-extended to XLEN.

Parameters:
- XLEN, 32, width of sign-extended immediate (>=32).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- PC_W, 32, PC width carried alongside each instruction.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all buffered and output instructions
- in_valid  in  1  fetch offers in_inst/in_pc
- in_ready  out  1  FIFO can accept
- in_inst  in  32  raw instruction
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts bundle
- out_pc  out  PC_W  PC of bundle
- out_op  out  12  one-hot class: [0]lui [1]auipc [2]jal [3]jalr [4]branch [5]load [6]int-reg-imm [7]store [8]const-shift [9]int-reg-reg [10]fence [11]system
- out_fmt  out  6  one-hot format: [0]R [1]I [2]S [3]B [4]J [5]U
- out_funct3  out  3  inst[14:12]
- out_funct7  out  7  inst[31:25]
- out_rd / out_rs1 / out_rs2  out  5 each  inst[11:7] / [19:15] / [24:20]
- out_imm  out  XLEN  selected immediate
- out_illegal  out  1  bundle is an illegal encoding
- out_muldiv  out  1  M-extension op (see Optional Feature)
- count  out  $clog2(DEPTH)+1  FIFO occupancy (excludes output register)

Behaviour:
- Reset (rst_n low at an edge): count=0, FIFO pointers=0, out_valid=0. All out_* data fields=0. in_ready=1 after reset.
- in_ready = (count != DEPTH). Push occurs when in_valid && in_ready. When full, no push even if a pop happens in the same cycle.
- Output register load condition: FIFO non-empty && (!out_valid || out_ready). On load, the head is decoded and popped. If the FIFO is empty and out_ready is high, out_valid clears.
- No FIFO bypass. Minimum latency from accept edge to out_valid is 2 edges. Sustained throughput is 1 instruction/cycle.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
- Bundle fields hold stable while out_valid && !out_ready.
- flush has priority over everything. At the next edge: count=0, pointers=0, out_valid=0, and any concurrent push is dropped. in_ready is unaffected.
- out_imm by class, all sign-extended from the top source bit:
  - I-type (jalr, load, int-reg-imm, fence, system): inst[31:20]
  - const-shift: zero-extended inst[24:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - U: {inst[31:12], 12'h000}
  - R-type: 0
- Illegal when any of:
  - inst[1:0] != 2'b11
  - opcode is not one of the 12 classes
  - int-reg-reg with funct7 not 0000000/0100000, or funct7=0100000 with funct3 not 000/101
  - const-shift with funct7 != 0000000, except 0100000 with funct3=101
  - branch funct3 010/011
  - load funct3 011/110/111
  - store funct3 >= 011
  - jalr funct3 != 000
- Illegal bundle: out_op=0, out_fmt=0, out_imm=0, out_illegal=1. Register fields and PC still pass through.

Optional Feature:
- Macro: DEC_RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 is legal. It gives out_op[9]=1, out_fmt[0]=1, out_muldiv=1.
- Undefined: that encoding is illegal, and out_muldiv is tied to 0. The port is present in both builds.

Decomposition:
- Package rv32i_dec_pkg holds: opcode localparams, out_op bit-index constants, out_fmt bit-index constants, and a packed struct typedef for the decoded bundle.
- Sub-module inst_dec_comb: purely combinational decode, illegal check and immediate generation on the FIFO head.
- inst_dec_queue holds the FIFO, handshake and output register.

Test Plan:
- After reset, push 0x00500093 at pc 0x100, out_ready=1 -> out_valid 2 edges later; out_op[6]=1, out_fmt[1]=1, rd=1, rs1=0, imm=0x00000005, illegal=0.
- Push 0xFE000EE3 (beq x0,x0,-4) -> out_op[4]=1, out_fmt[3]=1, out_imm=0xFFFFFFFC.
- Hold out_ready=0, offer 8 back-to-back instructions (DEPTH=4) -> exactly 5 accepted, count=4, in_ready=0. Releasing out_ready yields all 5 in order, one per cycle.
- Push 0x00000000 then 0x40001033 -> both bundles out_illegal=1, out_op=0, out_imm=0.
- With 3 instructions queued, assert flush together with in_valid -> next edge count=0, out_valid=0, concurrent instruction never appears.
- Push 0x022081B3 (mul x3,x1,x2):
  - with DEC_RV32M_EN: out_muldiv=1, illegal=0, rd=3, rs1=1, rs2=2.
  - without: out_illegal=1.
